// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg
//   Shared definitions for the instruction-issue sequencer.
//   - ISSUE_STATE_BITS : width of the sequencer state encoding
//   - issue_state_e    : sequencer states (BOOT, RUN, MEM, HALT)
//   - DEFAULT_WORD_BITS: default PC / address width used by issue_ctrl
package issue_ctrl_pkg;

    localparam int ISSUE_STATE_BITS  = 2;
    localparam int DEFAULT_WORD_BITS = 32;

    typedef enum logic [ISSUE_STATE_BITS-1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_MEM  = 2'd2,
        ST_HALT = 2'd3
    } issue_state_e;

endpackage

// File: rtl/issue_ctrl_timeout_cnt.sv
// issue_timeout_cnt
//   Wait counter for a data-memory access. Only instantiated by issue_ctrl
//   when ISSUE_CTRL_MEM_TIMEOUT_EN is defined.
//   Ports:
//     clk     : clock, rising edge
//     rst     : synchronous active-high reset
//     clear   : force the count to zero (takes priority over enable)
//     enable  : count one wait cycle
//     expired : high while enabled in the cycle that brings the count to
//               MEM_TIMEOUT, so the access lasts exactly MEM_TIMEOUT cycles
module issue_timeout_cnt
    import issue_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                    CNT_BITS = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_BITS-1:0]   CNT_LAST = CNT_BITS'(MEM_TIMEOUT - 1);

    logic [CNT_BITS-1:0] count_reg;
    logic [CNT_BITS-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable) begin
            count_next = count_reg + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // The current wait cycle is the MEM_TIMEOUT-th one.
    assign expired = enable && (count_reg == CNT_LAST);

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl
//   Instruction-issue sequencer: owns the PC, gates instruction valid into
//   the decoder, selects the next PC from decoded jumps, and stalls issue
//   across a data-memory req/ack access. Provides a debug halt taken at
//   instruction boundaries.
//   Optional feature: ISSUE_CTRL_MEM_TIMEOUT_EN adds a MEM wait timeout with
//   a sticky o_mem_err flag; without it MEM waits forever and o_mem_err = 0.
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     o_pc, o_inst_valid            : fetch address, issue strobe to decoder
//     i_jr, i_jr_addr               : register-indirect jump
//     i_jal_addr_valid, i_jal_addr  : decoded JAL
//     i_j_addr_valid, i_j_addr      : decoded J
//     i_read_req, i_write_req       : decoded LW / ST
//     o_mem_req, o_mem_we, i_mem_ack: data-memory handshake
//     o_load_we                     : load write-back pulse
//     o_link_we, o_link_data        : JAL link write
//     i_halt, o_halted              : debug halt request / acknowledge
//     o_mem_err                     : sticky memory timeout flag
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int                   WORD_BITS   = DEFAULT_WORD_BITS,
    parameter logic [WORD_BITS-1:0] RESET_PC    = '0,
    parameter int                   MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [WORD_BITS-1:0] o_pc,
    output logic                 o_inst_valid,
    input  logic                 i_jr,
    input  logic [WORD_BITS-1:0] i_jr_addr,
    input  logic                 i_jal_addr_valid,
    input  logic [WORD_BITS-1:0] i_jal_addr,
    input  logic                 i_j_addr_valid,
    input  logic [WORD_BITS-1:0] i_j_addr,
    input  logic                 i_read_req,
    input  logic                 i_write_req,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    input  logic                 i_mem_ack,
    output logic                 o_load_we,
    output logic                 o_link_we,
    output logic [WORD_BITS-1:0] o_link_data,
    input  logic                 i_halt,
    output logic                 o_halted,
    output logic                 o_mem_err
);

    issue_state_e         state_reg, state_next;
    logic [WORD_BITS-1:0] pc_reg, pc_next;
    logic [WORD_BITS-1:0] pc_inc;
    logic                 mem_req_reg;
    logic                 mem_we_reg, mem_we_next;
    logic                 halted_reg;

`ifdef ISSUE_CTRL_MEM_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;
    logic mem_err_reg, mem_err_next;
`endif

    // Wraps naturally modulo 2^WORD_BITS.
    assign pc_inc = pc_reg + WORD_BITS'(1);

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        mem_we_next  = mem_we_reg;
        o_inst_valid = 1'b0;
        o_load_we    = 1'b0;
        o_link_we    = 1'b0;
`ifdef ISSUE_CTRL_MEM_TIMEOUT_EN
        tmo_clear    = 1'b0;
        tmo_enable   = 1'b0;
        mem_err_next = mem_err_reg;
`endif
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (i_halt) begin
                    // Instruction held back; it issues again after the halt.
                    state_next = ST_HALT;
                end else begin
                    o_inst_valid = 1'b1;
                    if (i_read_req || i_write_req) begin
                        // PC stays on the load/store until the access completes;
                        // any jump decode this cycle is meaningless.
                        state_next  = ST_MEM;
                        mem_we_next = i_write_req;
`ifdef ISSUE_CTRL_MEM_TIMEOUT_EN
                        tmo_clear   = 1'b1;
`endif
                    end else begin
                        o_link_we = i_jal_addr_valid;
                        if (i_jr) begin
                            pc_next = i_jr_addr;
                        end else if (i_jal_addr_valid) begin
                            pc_next = i_jal_addr;
                        end else if (i_j_addr_valid) begin
                            pc_next = i_j_addr;
                        end else begin
                            pc_next = pc_inc;
                        end
                    end
                end
            end
            ST_MEM: begin
                if (i_mem_ack) begin
                    o_load_we  = !mem_we_reg;
                    pc_next    = pc_inc;
                    state_next = ST_RUN;
                end else begin
`ifdef ISSUE_CTRL_MEM_TIMEOUT_EN
                    tmo_enable = 1'b1;
                    if (tmo_expired) begin
                        // Give up on the access: skip the instruction, flag it.
                        pc_next      = pc_inc;
                        state_next   = ST_RUN;
                        mem_err_next = 1'b1;
                    end
`endif
                end
            end
            ST_HALT: begin
                if (!i_halt) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_BOOT;
            pc_reg      <= RESET_PC;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            halted_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            // Registered copies of "in MEM" / "in HALT" for glitch-free outputs.
            mem_req_reg <= (state_next == ST_MEM);
            mem_we_reg  <= mem_we_next;
            halted_reg  <= (state_next == ST_HALT);
        end
    end

`ifdef ISSUE_CTRL_MEM_TIMEOUT_EN
    issue_timeout_cnt #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err_reg <= 1'b0;
        end else begin
            mem_err_reg <= mem_err_next;
        end
    end

    assign o_mem_err = mem_err_reg;
`else
    // Timeout limit has no meaning without the timeout feature.
    if (MEM_TIMEOUT < 1) begin : g_timeout_cfg_unused
    end

    assign o_mem_err = 1'b0;
`endif

    assign o_pc        = pc_reg;
    assign o_mem_req   = mem_req_reg;
    assign o_mem_we    = mem_we_reg;
    assign o_halted    = halted_reg;
    assign o_link_data = pc_inc;

endmodule
